// File: rtl/tetris_input_scheduler.sv
// Turns PS/2 make/break pairs into held state for the eight game keys, generates DAS/ARR
// horizontal auto-shift and soft-drop repeats, and arbitrates everything into one valid/ready stream.
module tetris_input_scheduler #(
  parameter int DAS_CYC = 17_000_000,
  parameter int ARR_CYC = 5_000_000,
  parameter int SDR_CYC = 5_000_000,
  parameter int CNT_W   = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       make_break,
  output logic       action_valid,
  output logic [2:0] action,
  input  logic       action_ready,
  output logic [7:0] keys_held
);

  localparam logic [2:0] A_LEFT      = 3'd0;
  localparam logic [2:0] A_RIGHT     = 3'd1;
  localparam logic [2:0] A_DOWN      = 3'd2;
  localparam logic [2:0] A_ROT_CW    = 3'd3;
  localparam logic [2:0] A_ROT_CCW   = 3'd4;
  localparam logic [2:0] A_HARD_DROP = 3'd5;
  localparam logic [2:0] A_HOLD      = 3'd6;
  localparam logic [2:0] A_PAUSE     = 3'd7;

  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYC - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYC - 1);
  localparam logic [CNT_W-1:0] SDR_LAST = CNT_W'(SDR_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    H_IDLE,
    H_DAS,
    H_ARR
  } hstate_e;

  logic [7:0]       prev_code_q, prev_code_d;
  logic             prev_mb_q, prev_mb_d;
  logic [7:0]       keys_held_q, keys_held_d;
  logic [7:0]       pending_q, pending_d;
  hstate_e          hstate_q, hstate_d;
  logic             hdir_q, hdir_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [2:0]       action_q, action_d;
  logic             action_valid_q, action_valid_d;

  logic       key_hit;
  logic [2:0] key_idx;
  logic       is_event;
  logic       do_make;
  logic       do_break;
  logic       is_horiz;
  logic       h_opp;
  logic       h_req;
  logic       h_req_dir;
  logic       s_req;
  logic [7:0] req;
  logic [7:0] pending_cleared;
  logic [2:0] grant_idx;
  logic       grant_any;

  always_comb begin
    key_hit = 1'b1;
    key_idx = A_LEFT;
    case (scan_code)
      8'h6B:   key_idx = A_LEFT;
      8'h74:   key_idx = A_RIGHT;
      8'h72:   key_idx = A_DOWN;
      8'h75:   key_idx = A_ROT_CW;
      8'h1A:   key_idx = A_ROT_CCW;
      8'h29:   key_idx = A_HARD_DROP;
      8'h21:   key_idx = A_HOLD;
      8'h76:   key_idx = A_PAUSE;
      default: key_hit = 1'b0;
    endcase
  end

  // The keyboard holds its last code/flag, so only a change of the pair counts as a key event.
  always_comb begin
    prev_code_d = scan_code;
    prev_mb_d   = make_break;
    is_event    = (scan_code != prev_code_q) || (make_break != prev_mb_q);
    do_make     = is_event && key_hit && make_break && !keys_held_q[key_idx];
    do_break    = is_event && key_hit && !make_break;
    is_horiz    = (key_idx == A_LEFT) || (key_idx == A_RIGHT);
    keys_held_d = keys_held_q;
    if (do_make) begin
      keys_held_d[key_idx] = 1'b1;
    end else if (do_break) begin
      keys_held_d[key_idx] = 1'b0;
    end
  end

  always_comb begin
    hstate_d  = hstate_q;
    hdir_d    = hdir_q;
    hcnt_d    = hcnt_q;
    h_req     = 1'b0;
    h_req_dir = hdir_q;
    h_opp     = ~hdir_q;
    case (hstate_q)
      H_IDLE: begin
        if (do_make && is_horiz) begin
          hstate_d = H_DAS;
          hdir_d   = key_idx[0];
          hcnt_d   = '0;
        end
      end
      H_DAS, H_ARR: begin
        if (do_make && is_horiz) begin
          hstate_d = H_DAS;
          hdir_d   = key_idx[0];
          hcnt_d   = '0;
        end else if (do_break && is_horiz && (key_idx[0] == hdir_q)) begin
          hcnt_d = '0;
          // Releasing the active direction hands off to the other one if it is still down.
          if (keys_held_q[{2'b00, h_opp}]) begin
            hstate_d  = H_DAS;
            hdir_d    = h_opp;
            h_req     = 1'b1;
            h_req_dir = h_opp;
          end else begin
            hstate_d = H_IDLE;
          end
        end else if (hcnt_q == ((hstate_q == H_DAS) ? DAS_LAST : ARR_LAST)) begin
          hstate_d = H_ARR;
          hcnt_d   = '0;
          h_req    = 1'b1;
        end else begin
          hcnt_d = hcnt_q + CNT_ONE;
        end
      end
      default: begin
        hstate_d = H_IDLE;
        hcnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    scnt_d = scnt_q;
    s_req  = 1'b0;
    if ((do_make || do_break) && (key_idx == A_DOWN)) begin
      scnt_d = '0;
    end else if (keys_held_q[A_DOWN]) begin
      if (scnt_q == SDR_LAST) begin
        scnt_d = '0;
        s_req  = 1'b1;
      end else begin
        scnt_d = scnt_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    grant_any = |pending_q;
    grant_idx = A_LEFT;
    if (pending_q[A_PAUSE])          grant_idx = A_PAUSE;
    else if (pending_q[A_HOLD])      grant_idx = A_HOLD;
    else if (pending_q[A_HARD_DROP]) grant_idx = A_HARD_DROP;
    else if (pending_q[A_ROT_CW])    grant_idx = A_ROT_CW;
    else if (pending_q[A_ROT_CCW])   grant_idx = A_ROT_CCW;
    else if (pending_q[A_LEFT])      grant_idx = A_LEFT;
    else if (pending_q[A_RIGHT])     grant_idx = A_RIGHT;
    else if (pending_q[A_DOWN])      grant_idx = A_DOWN;
  end

  // New requests are OR-ed in after the grant clears its bit, so a same-cycle request survives.
  always_comb begin
    req = '0;
    if (do_make) req[key_idx] = 1'b1;
    if (h_req)   req[{2'b00, h_req_dir}] = 1'b1;
    if (s_req)   req[A_DOWN] = 1'b1;

    pending_cleared = pending_q;
    action_d        = action_q;
    action_valid_d  = action_valid_q;
    if (!action_valid_q || action_ready) begin
      if (grant_any) begin
        action_valid_d             = 1'b1;
        action_d                   = grant_idx;
        pending_cleared[grant_idx] = 1'b0;
      end else begin
        action_valid_d = 1'b0;
      end
    end
    pending_d = pending_cleared | req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_code_q    <= 8'h00;
      prev_mb_q      <= 1'b0;
      keys_held_q    <= '0;
      pending_q      <= '0;
      hstate_q       <= H_IDLE;
      hdir_q         <= 1'b0;
      hcnt_q         <= '0;
      scnt_q         <= '0;
      action_q       <= '0;
      action_valid_q <= 1'b0;
    end else begin
      prev_code_q    <= prev_code_d;
      prev_mb_q      <= prev_mb_d;
      keys_held_q    <= keys_held_d;
      pending_q      <= pending_d;
      hstate_q       <= hstate_d;
      hdir_q         <= hdir_d;
      hcnt_q         <= hcnt_d;
      scnt_q         <= scnt_d;
      action_q       <= action_d;
      action_valid_q <= action_valid_d;
    end
  end

  assign action_valid = action_valid_q;
  assign action       = action_q;
  assign keys_held    = keys_held_q;

endmodule
